sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single external async SRAM (18-bit address, 20-bit data) between two requesters.
- Read port serves the VGA scan-out path; write port serves the rasterizer point writer.
- Owns all SRAM strobes and the SRAM_DQ tristate, sequences timed read and write cycles, and inserts bus turnaround.
- Read port has priority, with a starvation guard for writes.

Parameters:
- ACCESS_CYCLES, 2: clock cycles the SRAM read sample or WE_N-low pulse lasts (≥1).
- MAX_RD_STREAK, 4: consecutive read grants allowed while wr_req is pending before a write is forced (≥1).

Ports:
- CLOCK_50  in  1  single clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- rd_req  in  1  read request, level, held until rd_ack.
- rd_addr  in  18  read address, stable while rd_req=1.
- rd_ack  out  1  one-cycle pulse in the final cycle of the granted read.
- rd_data  out  20  registered read data.
- rd_valid  out  1  one-cycle pulse, cycle after rd_ack; rd_data valid.
- wr_req  in  1  write request, level, held until wr_ack.
- wr_addr  in  18  write address.
- wr_data  in  20  write data.
- wr_ack  out  1  one-cycle pulse in the final cycle of the granted write.
- busy  out  1  state != IDLE.
- SRAM_ADDR  out  18  SRAM address.
- SRAM_DQ  inout  20  SRAM data; driven only in write states, else hi-Z.
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N  out  1 each  active-low strobes.
- SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0.

Behaviour:
- States and strobes:
  - IDLE: CE_N=1, OE_N=1, WE_N=1, DQ hi-Z.
  - RD: CE_N=0, OE_N=0, WE_N=1, DQ hi-Z.
  - WR_SETUP: CE_N=0, OE_N=1, WE_N=1, DQ driven.
  - WR_PULSE: same as WR_SETUP but WE_N=0.
  - WR_HOLD: same as WR_SETUP (WE_N=1, DQ driven).
- Arbitration (IDLE only, every cycle): rd_req alone → RD; wr_req alone → WR_SETUP; both → RD, unless rd_streak==MAX_RD_STREAK, then WR_SETUP.
- rd_streak:
  - +1 on each read grant while wr_req=1.
  - Cleared on any write grant, or in any cycle wr_req=0.
  - Saturates at MAX_RD_STREAK.
- Request capture: address and data are latched into internal registers at grant. SRAM_ADDR and write data come from these registers, so requester changes mid-access are ignored.
- RD:
  - Lasts ACCESS_CYCLES cycles; rd_ack=1 in the last cycle.
  - On the edge ending that cycle, SRAM_DQ is captured into rd_data and the state returns to IDLE.
  - rd_valid=1 the following cycle.
  - Latency from grant edge to rd_valid: ACCESS_CYCLES+1 cycles.
- WR: WR_SETUP 1 cycle → WR_PULSE ACCESS_CYCLES cycles → WR_HOLD 1 cycle (wr_ack=1) → IDLE. Total ACCESS_CYCLES+2 cycles.
- Requester handshake: deassert req, or present a new request, in the cycle after ack. IDLE arbitrates on req values in that cycle.
- Turnaround: every access returns through IDLE (≥1 cycle with OE_N=1 and DQ hi-Z). The controller never drives DQ while OE_N=0.
- Strobes, acks and valid come from registered state/counter only; no combinational path from req to SRAM pins.
- Reset (any state, including mid-access): on the next edge, state=IDLE, strobes inactive, DQ hi-Z. rd_ack, wr_ack, rd_valid=0; rd_data=0; rd_streak=0; SRAM_ADDR=0. An aborted access never produces an ack.
- Reset outputs: busy=0. Statistics counters (when compiled in) = 0.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- When defined: adds output ports rd_count (32) and wr_count (32).
  - Each increments by 1 per rd_ack and wr_ack pulse respectively; wraps at 2^32.
  - Both clear on RESET.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then single write 0x00010 ← 0x0ABCD (ACCESS_CYCLES=2) → WE_N low exactly 2 cycles; DQ driven 4 cycles; wr_ack in 4th cycle after grant; memory model holds 0x0ABCD.
- Read 0x00010 → OE_N low 2 cycles with DQ hi-Z; rd_ack in 2nd cycle; rd_valid next cycle with rd_data=0x0ABCD.
- rd_req held continuously and wr_req raised (MAX_RD_STREAK=4) → exactly 4 read grants, then one write, then reads resume; rd_streak=0 after the write.
- RESET asserted during 1st WR_PULSE cycle → next cycle WE_N=1, CE_N=1, DQ hi-Z, busy=0; no wr_ack ever pulses for that request.
- 100 random back-to-back alternating read/write requests → checker sees no cycle with OE_N=0 and DQ driven, ≥1 IDLE cycle between accesses, and all read data matches the model.
- With SRAM_ARB_STATS_EN: 10 reads and 7 writes → rd_count=10, wr_count=7; after RESET both 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async SRAM (18-bit addr, 20-bit data) between
// a priority read port (VGA scan-out) and a write port (rasterizer). Sequences
// timed read/write cycles and returns to IDLE between accesses for turnaround.
// Optional build macro: SRAM_ARB_STATS_EN adds rd_count/wr_count ack counters.
module sram_port_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        rd_req,
  input  logic [17:0] rd_addr,
  output logic        rd_ack,
  output logic [19:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_req,
  input  logic [17:0] wr_addr,
  input  logic [19:0] wr_data,
  output logic        wr_ack,
  output logic        busy,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [19:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [SW-1:0]   rd_streak;
  logic [17:0]     addr_q;
  logic [19:0]     wdata_q;
  logic            grant_rd, grant_wr;
  logic            last;
  logic            dq_oe;

  // cnt tracks the cycle index inside RD and WR_PULSE
  assign last = (cnt == CW'(ACCESS_CYCLES - 1));

  // next-state and arbitration; grants happen only from IDLE
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && !(wr_req && rd_streak == SW'(MAX_RD_STREAK))) begin
          grant_rd = 1'b1;
          state_d  = RD;
          cnt_d    = '0;
        end else if (wr_req) begin
          grant_wr = 1'b1;
          state_d  = WR_SETUP;
          cnt_d    = '0;
        end
      end
      RD: begin
        if (last) state_d = IDLE;
        else      cnt_d   = cnt + CW'(1);
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
      end
      WR_PULSE: begin
        if (last) state_d = WR_HOLD;
        else      cnt_d   = cnt + CW'(1);
      end
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // strobes decoded from the registered state only
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    case (state)
      RD: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        SRAM_CE_N = 1'b0;
        dq_oe     = 1'b1;
      end
      WR_PULSE: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end
      default: ;
    endcase
  end

  assign SRAM_DQ   = dq_oe ? wdata_q : 20'bz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign rd_ack    = (state == RD) && last;
  assign wr_ack    = (state == WR_HOLD);
  assign busy      = (state != IDLE);

  // state register, request capture at grant, streak guard, read data capture
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_streak <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rd_valid <= rd_ack;
      if (rd_ack) rd_data <= SRAM_DQ;
      if (grant_rd) addr_q <= rd_addr;
      if (grant_wr) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end
      if (!wr_req || grant_wr)
        rd_streak <= '0;
      else if (grant_rd && rd_streak != SW'(MAX_RD_STREAK))
        rd_streak <= rd_streak + SW'(1);
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // completed-access counters, wrapping at 2^32
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_ack) rd_count <= rd_count + 32'd1;
      if (wr_ack) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule
